// File: rtl/pi_request.sv
// pi_request: command FIFO and Pi bus-cycle sequencer in front of `sync`.
// Commands queue from the Pi side; the head command raises `pending`, is
// driven onto the bus during the Pi slot, and retires with a one-cycle
// response once `done` arrives.
// Optional feature macro: PI_REQUEST_TIMEOUT_EN (abort a WAIT that never
// sees `strobe` after TIMEOUT_CYCLES clk16 cycles; response flagged rsp_err).
module pi_request #(
   parameter int unsigned ADDR_WIDTH     = 17,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned DEPTH          = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk16,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  pending,
   input  logic                  strobe,
   input  logic                  done,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic                  bus_we,
   output logic [DATA_WIDTH-1:0] bus_data_out,
   output logic                  bus_data_oe,
   input  logic [DATA_WIDTH-1:0] bus_data_in,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RELEASE} state_t;

   cmd_t             mem [DEPTH];
   cmd_t             head;
   logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_nx, rd_nx;
   logic             empty;
   logic             push, pop;

   state_t                state, state_d;
   logic                  pending_d, we_d, oe_d, rsp_valid_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [DATA_WIDTH-1:0] dout_d, rsp_data_d;

   assign push  = cmd_valid && cmd_ready;
   assign wr_nx = wr_ptr + PTR_W'(push);
   assign rd_nx = rd_ptr + PTR_W'(pop);
   assign head  = mem[rd_ptr[IDX_W-1:0]];

   // FIFO storage; written only on an accepted push
   always_ff @(posedge clk16) begin
      if (push) mem[wr_ptr[IDX_W-1:0]] <= '{we: cmd_we, addr: cmd_addr, data: cmd_data};
   end

   // FIFO pointers with registered empty/ready flags derived from the next pointers
   always_ff @(posedge clk16 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         empty     <= 1'b1;
         cmd_ready <= 1'b1;
      end else begin
         wr_ptr    <= wr_nx;
         rd_ptr    <= rd_nx;
         empty     <= (wr_nx == rd_nx);
         cmd_ready <= !((wr_nx[IDX_W-1:0] == rd_nx[IDX_W-1:0]) &&
                        (wr_nx[IDX_W] != rd_nx[IDX_W]));
      end
   end

`ifdef PI_REQUEST_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             rsp_err_d;
`else
   // Timeout disabled: the limit has no hardware behind it.
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
   assign rsp_err        = 1'b0;
`endif

   // Next-state and next-output logic of the transaction sequencer
   always_comb begin
      state_d     = state;
      pending_d   = pending;
      addr_d      = bus_addr;
      we_d        = bus_we;
      dout_d      = bus_data_out;
      oe_d        = bus_data_oe;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data;
      pop         = 1'b0;
`ifdef PI_REQUEST_TIMEOUT_EN
      cnt_d       = cnt;
      rsp_err_d   = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (!empty) begin
               addr_d    = head.addr;
               we_d      = head.we;
               dout_d    = head.data;
               oe_d      = head.we;
               pending_d = 1'b1;
               state_d   = S_WAIT;
`ifdef PI_REQUEST_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         S_WAIT: begin
            // `done` here is stale from a previous slot and is ignored
            if (strobe) begin
               if (!bus_we) rsp_data_d = bus_data_in;
               state_d = S_ACCESS;
            end
`ifdef PI_REQUEST_TIMEOUT_EN
            else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               pending_d   = 1'b0;
               oe_d        = 1'b0;
               pop         = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_data_d  = '0;
               state_d     = S_RELEASE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
`endif
         end
         S_ACCESS: begin
            if (strobe && !bus_we) rsp_data_d = bus_data_in;
            if (done) begin
               pending_d   = 1'b0;
               oe_d        = 1'b0;
               pop         = 1'b1;
               rsp_valid_d = 1'b1;
               if (bus_we) rsp_data_d = '0;
               state_d     = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (!done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk16 or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         pending      <= 1'b0;
         bus_addr     <= '0;
         bus_we       <= 1'b0;
         bus_data_out <= '0;
         bus_data_oe  <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
`ifdef PI_REQUEST_TIMEOUT_EN
         cnt          <= '0;
         rsp_err      <= 1'b0;
`endif
      end else begin
         state        <= state_d;
         pending      <= pending_d;
         bus_addr     <= addr_d;
         bus_we       <= we_d;
         bus_data_out <= dout_d;
         bus_data_oe  <= oe_d;
         rsp_valid    <= rsp_valid_d;
         rsp_data     <= rsp_data_d;
`ifdef PI_REQUEST_TIMEOUT_EN
         cnt          <= cnt_d;
         rsp_err      <= rsp_err_d;
`endif
      end
   end

endmodule

// File: doc/pi_request.md
Name: pi_request

Overview:
- Command buffer and transaction sequencer between the Raspberry Pi command front end and `sync`.
- Queues read/write requests from the Pi side and raises `pending` toward `sync`.
- Drives address, data and direction onto the shared bus during the Pi's slot, and captures read data while `strobe` is high.
- Drops `pending` once `done` is seen, then returns a one-cycle response.

Parameters:
- ADDR_WIDTH, 17, width of the bus address.
- DATA_WIDTH, 8, width of the bus data.
- DEPTH, 2, command FIFO entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 4096, clk16 cycles allowed from `pending` rise to `strobe`; used only with the optional feature.

Ports:
- clk16  in  1  16 MHz system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  Pi command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_data  in  DATA_WIDTH  write data; ignored for reads.
- pending  out  1  request to `sync`.
- strobe  in  1  from `sync`: Pi bus cycle is active.
- done  in  1  from `sync`: Pi cycle is complete; held until `pending` falls.
- bus_addr  out  ADDR_WIDTH  address of the head command.
- bus_we  out  1  direction of the head command.
- bus_data_out  out  DATA_WIDTH  write data of the head command.
- bus_data_oe  out  1  data-bus drive enable.
- bus_data_in  in  DATA_WIDTH  read data from the bus.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  completion was aborted by timeout.

Behaviour:
- Reset (asynchronous, active-low) clears:
  - FIFO (empty), state to IDLE;
  - `pending`, `bus_*`, `bus_data_oe`, `rsp_*` to 0;
  - `cmd_ready` to 1.
  A reset mid-transaction drops `pending` immediately; `sync` then clears `done`. The in-flight command is lost.
- FIFO:
  - Push when `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`, using the registered full flag. A push while full is rejected even if a pop happens the same cycle.
  - Pop happens only on completion.
  - Read/write pointers are log2(DEPTH)+1 bits and wrap naturally.
- State machine:
  - IDLE: if the FIFO is non-empty, load `bus_addr`, `bus_we` and `bus_data_out` from the head entry, set `pending`=1, go to WAIT. `pending` rises 2 cycles after the first push into an empty FIFO.
  - WAIT:
    - `bus_data_oe` = `bus_we`; `bus_*` are held stable.
    - On `strobe`=1, go to ACCESS.
    - `done`=1 without a prior `strobe` is ignored.
  - ACCESS:
    - Each cycle `strobe`=1, register `bus_data_in` into `rsp_data` if this is a read. The last `strobe`-high sample wins.
    - On `done`=1:
      - drop `pending` and `bus_data_oe`;
      - pop the FIFO and pulse `rsp_valid`; for writes, `rsp_data` = 0;
      - go to RELEASE.
  - RELEASE: wait for `done`=0, then go to IDLE. This gives at least one idle cycle between transactions.
- Command order:
  - Exactly one Pi bus cycle per command; commands complete strictly in FIFO order.
  - Back-to-back commands each need a separate `select` period, because `sync` needs `pending` low to clear `done`.
- `rsp_valid` is never asserted for two consecutive cycles.
- `rsp_err` is 0 except as described under the optional feature.

Optional Feature:
- Macro: PI_REQUEST_TIMEOUT_EN.
- Defined:
  - A counter runs while in WAIT.
  - If it reaches TIMEOUT_CYCLES before `strobe`: drop `pending`, pop the head, pulse `rsp_valid` with `rsp_err`=1 and `rsp_data`=0, go to RELEASE.
  - The counter clears on entering WAIT and on reset.
- Not defined:
  - No counter logic; WAIT waits indefinitely.
  - `rsp_err` is tied to 0.

Test Plan:
- Reset then idle → `pending`=0, `cmd_ready`=1, `rsp_valid`=0. Assert `reset_n` low mid-WAIT → `pending` falls within 1 ns (before the next clk16 edge); FIFO reads empty.
- Write: addr 0x08000, data 0xA5 → `pending` rises 2 cycles after the push. `bus_addr`=0x08000, `bus_data_out`=0xA5, `bus_data_oe`=1 through `strobe`. On `done`, exactly one `rsp_valid` pulse, `rsp_data`=0x00, `pending`=0.
- Read: addr 0x0E810, `bus_data_in`=0x3C during `strobe` → `bus_data_oe`=0, `rsp_data`=0x3C at `rsp_valid`.
- Push 3 commands with DEPTH=2 → third sees `cmd_ready`=0 until the first completes. Responses arrive in push order, one per `select` period, with `pending` low between them.
- `bus_data_in` changes 0x11→0x22 within one `strobe` window → `rsp_data`=0x22.
- With PI_REQUEST_TIMEOUT_EN, TIMEOUT_CYCLES=16, `strobe` held 0 → `rsp_valid`=1, `rsp_err`=1 at cycle 16 of WAIT, `pending` drops. Without the macro, `pending` stays 1.
